uart_led_probe: RTL and testbench

//  Parametrised SoC I/O probe for the led_uart_soc family of top levels.
//  It drives a DUT's uart_rx with framed bytes from a valid/ready port and decodes the DUT's uart_tx into an RX FIFO.
//  It also watches the DUT's LED bus for changes, and runs an activity watchdog.

---
 rtl/uart_probe_pkg.sv | 47 ++++
 rtl/uart_probe_fifo.sv | 47 ++++
 rtl/uart_led_probe.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_uart_led_probe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_probe_pkg.sv
// Shared constants, FSM encodings and helpers for the UART/LED probe.
package uart_probe_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Parity bit to transmit for the low nbits of data under the given mode.
  function automatic logic parity_bit(input logic [8:0] data, input int nbits, input int mode);
    logic ones;
    ones = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) ones = ones ^ data[i];
    end
    return (mode == PARITY_ODD) ? ~ones : ones;
  endfunction

endpackage

// File: rtl/uart_probe_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees a slot for a same-cycle push when full.
module uart_probe_fifo
  import uart_probe_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_led_probe.sv
// SoC I/O probe: UART transmitter into the DUT, UART receiver with FIFO from the DUT,
// LED change tracker and an activity watchdog.
module uart_led_probe
  import uart_probe_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 16,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16,
  parameter int LED_W           = 8,
  parameter int WATCHDOG_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_rx,
  input  logic                 uart_tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overflow,
  input  logic [LED_W-1:0]     led,
  output logic [LED_W-1:0]     led_value,
  output logic                 led_change,
  output logic [15:0]          led_change_count,
  output logic                 watchdog_expired
);

  localparam int CW = clog2(CLKS_PER_BIT) + 1;

  // ---------------- TX ----------------
  tx_state_t            tx_state_reg, tx_state_next;
  logic [CW-1:0]        tx_cnt_reg, tx_cnt_next;
  logic [3:0]           tx_bit_reg, tx_bit_next;
  logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                 tx_par_reg, tx_par_next;
  logic                 tx_line_reg, tx_line_next;
  logic                 tx_bit_end;
  logic                 tx_handshake;
  logic [8:0]           tx_data_ext;

  assign tx_ready     = (tx_state_reg == TX_IDLE);
  assign tx_handshake = tx_valid & tx_ready;
  assign tx_bit_end   = (tx_cnt_reg == CW'(CLKS_PER_BIT - 1));
  assign uart_rx      = tx_line_reg;

  always_comb begin
    tx_data_ext = '0;
    tx_data_ext[DATA_BITS-1:0] = tx_data;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_par_next   = tx_par_reg;
    tx_line_next  = 1'b1;
    case (tx_state_reg)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_next = TX_START;
          tx_cnt_next   = '0;
          tx_shift_next = tx_data;
          tx_par_next   = parity_bit(tx_data_ext, DATA_BITS, PARITY);
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_next = TX_DATA;
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
        end else tx_cnt_next = tx_cnt_reg + CW'(1);
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_next   = '0;
          tx_shift_next = tx_shift_reg >> 1;
          if (tx_bit_reg == 4'(DATA_BITS - 1)) begin
            tx_bit_next   = '0;
            tx_state_next = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
          end else tx_bit_next = tx_bit_reg + 4'd1;
        end else tx_cnt_next = tx_cnt_reg + CW'(1);
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_next = TX_STOP;
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
        end else tx_cnt_next = tx_cnt_reg + CW'(1);
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == 4'(STOP_BITS - 1)) tx_state_next = TX_IDLE;
          else tx_bit_next = tx_bit_reg + 4'd1;
        end else tx_cnt_next = tx_cnt_reg + CW'(1);
      end
      default: tx_state_next = TX_IDLE;
    endcase
    // Line level is registered from the next state so the serial output never glitches.
    case (tx_state_next)
      TX_START:  tx_line_next = 1'b0;
      TX_DATA:   tx_line_next = tx_shift_next[0];
      TX_PARITY: tx_line_next = tx_par_next;
      default:   tx_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_line_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_par_reg   <= tx_par_next;
      tx_line_reg  <= tx_line_next;
    end
  end

  // ---------------- RX ----------------
  rx_state_t            rx_state_reg, rx_state_next;
  logic [CW-1:0]        rx_cnt_reg, rx_cnt_next;
  logic [3:0]           rx_bit_reg, rx_bit_next;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic                 rx_perr_reg, rx_perr_next;
  logic [1:0]           rx_sync_reg;
  logic                 rx_prev_reg;
  logic                 rx_sync;
  logic                 rx_bit_end;
  logic                 rx_push;
  logic [DATA_BITS+1:0] rx_push_data;
  logic [8:0]           rx_shift_ext;

  assign rx_sync      = rx_sync_reg[1];
  assign rx_bit_end   = (rx_cnt_reg == CW'(CLKS_PER_BIT - 1));
  assign rx_push_data = {~rx_sync, rx_perr_reg, rx_shift_reg};

  always_comb begin
    rx_shift_ext = '0;
    rx_shift_ext[DATA_BITS-1:0] = rx_shift_reg;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_perr_next  = rx_perr_reg;
    rx_push       = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync) begin
          rx_state_next = RX_START;
          rx_cnt_next   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_reg == CW'(CLKS_PER_BIT / 2 - 1)) begin
          rx_cnt_next = '0;
          rx_bit_next = '0;
          rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
        end else rx_cnt_next = rx_cnt_reg + CW'(1);
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync, rx_shift_reg[DATA_BITS-1:1]};
          if (rx_bit_reg == 4'(DATA_BITS - 1)) begin
            rx_perr_next  = 1'b0;
            rx_state_next = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
          end else rx_bit_next = rx_bit_reg + 4'd1;
        end else rx_cnt_next = rx_cnt_reg + CW'(1);
      end
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_next   = '0;
          rx_perr_next  = rx_sync ^ parity_bit(rx_shift_ext, DATA_BITS, PARITY);
          rx_state_next = RX_STOP;
        end else rx_cnt_next = rx_cnt_reg + CW'(1);
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_next   = '0;
          rx_push       = 1'b1;
          rx_state_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
        end else rx_cnt_next = rx_cnt_reg + CW'(1);
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_perr_reg  <= 1'b0;
      rx_sync_reg  <= 2'b11;
      rx_prev_reg  <= 1'b1;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_perr_reg  <= rx_perr_next;
      rx_sync_reg  <= {rx_sync_reg[0], uart_tx};
      rx_prev_reg  <= rx_sync;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS+1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 overflow_reg;

  uart_probe_fifo #(
    .WIDTH(DATA_BITS + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .push_data(rx_push_data),
    .pop      (rx_ready),
    .head_data(fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rx_valid      = ~fifo_empty;
  assign rx_data       = fifo_head[DATA_BITS-1:0];
  assign rx_parity_err = fifo_head[DATA_BITS];
  assign rx_frame_err  = fifo_head[DATA_BITS+1];
  assign rx_overflow   = overflow_reg;

  // A full FIFO is never empty, so rx_ready alone means the pop frees a slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_reg <= 1'b0;
    else if (rx_push && fifo_full && !rx_ready) overflow_reg <= 1'b1;
  end

  // ---------------- LED tracker and watchdog ----------------
  logic [LED_W-1:0] led_value_reg;
  logic [LED_W-1:0] led_prev_reg;
  logic             led_change_reg;
  logic [15:0]      led_count_reg;
  logic [31:0]      wd_cnt_reg, wd_cnt_next;
  logic             wd_expired_reg;

  assign led_value        = led_value_reg;
  assign led_change       = led_change_reg;
  assign led_change_count = led_count_reg;
  assign watchdog_expired = wd_expired_reg;

  always_comb begin
    wd_cnt_next = wd_cnt_reg;
    if (led_change_reg || rx_push || tx_handshake) wd_cnt_next = '0;
    else if (wd_cnt_reg != 32'hFFFF_FFFF) wd_cnt_next = wd_cnt_reg + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_value_reg  <= '0;
      led_prev_reg   <= '0;
      led_change_reg <= 1'b0;
      led_count_reg  <= '0;
      wd_cnt_reg     <= '0;
      wd_expired_reg <= 1'b0;
    end else begin
      led_value_reg  <= led;
      led_prev_reg   <= led_value_reg;
      led_change_reg <= (led_value_reg != led_prev_reg);
      if ((led_value_reg != led_prev_reg) && (led_count_reg != 16'hFFFF))
        led_count_reg <= led_count_reg + 16'd1;
      wd_cnt_reg <= wd_cnt_next;
      if (wd_cnt_next == 32'(WATCHDOG_CYCLES)) wd_expired_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_led_probe.sv
// Scoreboard bench: an 8N1 probe in loopback and an 8E1 probe fed by a bit-banged line.
module tb_uart_led_probe;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       dut_uart_rx;
  logic       dut_uart_tx;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overflow;
  logic [7:0] led;
  logic [7:0] led_value;
  logic       led_change;
  logic [15:0] led_change_count;
  logic       watchdog_expired;

  logic       bb_en;
  logic       bb_line;
  logic       bbp_line;

  logic       p_tx_ready;
  logic       p_uart_rx;
  logic [7:0] p_rx_data;
  logic       p_rx_parity_err;
  logic       p_rx_frame_err;
  logic       p_rx_valid;
  logic       p_rx_overflow;
  logic [7:0] p_led_value;
  logic       p_led_change;
  logic [15:0] p_led_change_count;
  logic       p_watchdog_expired;

  logic [9:0] q_main[$];
  logic [9:0] q_par[$];
  int         vectors;
  int         miscompares;

  assign dut_uart_tx = bb_en ? bb_line : dut_uart_rx;

  uart_led_probe #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .FIFO_DEPTH(16), .LED_W(8), .WATCHDOG_CYCLES(1000)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .uart_rx(dut_uart_rx), .uart_tx(dut_uart_tx),
    .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overflow(rx_overflow),
    .led(led), .led_value(led_value), .led_change(led_change),
    .led_change_count(led_change_count), .watchdog_expired(watchdog_expired)
  );

  uart_led_probe #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
    .FIFO_DEPTH(16), .LED_W(8), .WATCHDOG_CYCLES(1000)
  ) dut_p (
    .clk(clk), .reset(reset),
    .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(p_tx_ready),
    .uart_rx(p_uart_rx), .uart_tx(bbp_line),
    .rx_data(p_rx_data), .rx_parity_err(p_rx_parity_err), .rx_frame_err(p_rx_frame_err),
    .rx_valid(p_rx_valid), .rx_ready(1'b1), .rx_overflow(p_rx_overflow),
    .led(8'h00), .led_value(p_led_value), .led_change(p_led_change),
    .led_change_count(p_led_change_count), .watchdog_expired(p_watchdog_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  // Pops and compares whenever a probe presents a head entry that is being accepted.
  task automatic run_monitor();
    logic [9:0] got;
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      if (rx_valid && rx_ready) begin
        got = {rx_frame_err, rx_parity_err, rx_data};
        if (q_main.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL main_pop: got unexpected entry 0x%0h, expected none", got);
        end else begin
          exp = q_main.pop_front();
          check("main_pop", {22'd0, got}, {22'd0, exp});
        end
      end
      if (p_rx_valid) begin
        got = {p_rx_frame_err, p_rx_parity_err, p_rx_data};
        if (q_par.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL par_pop: got unexpected entry 0x%0h, expected none", got);
        end else begin
          exp = q_par.pop_front();
          check("par_pop", {22'd0, got}, {22'd0, exp});
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q_main.size() != 0 || q_par.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q_main.size() != 0 || q_par.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d entries outstanding, expected 0 within %0d cycles",
               q_main.size() + q_par.size(), budget);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic expect_push);
    int n;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    if (expect_push) q_main.push_back({2'b00, d});
    n = 0;
    while (!tx_ready && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_len", n, 160);
  endtask

  task automatic drive_bb(input int sel, input logic v);
    if (sel == 0) bb_line = v;
    else bbp_line = v;
  endtask

  task automatic bb_frame(input int sel, input logic [7:0] d, input logic par_en,
                          input logic par_val, input logic stop_val);
    @(posedge clk);
    #1;
    drive_bb(sel, 1'b0);
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      drive_bb(sel, d[i]);
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (par_en) begin
      drive_bb(sel, par_val);
      repeat (CPB) @(posedge clk);
      #1;
    end
    drive_bb(sel, stop_val);
    repeat (CPB) @(posedge clk);
    #1;
    drive_bb(sel, 1'b1);
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic step_led(input logic [7:0] v, input int cycles, inout int pulses);
    led = v;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (led_change) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int n;
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b1;
    led      = 8'h00;
    bb_en    = 1'b0;
    bb_line  = 1'b1;
    bbp_line = 1'b1;
    fork
      run_monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_ready", tx_ready, 1);
    check("rst_uart_rx", dut_uart_rx, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_overflow", rx_overflow, 0);
    check("rst_led_value", led_value, 0);
    check("rst_led_change", led_change, 0);
    check("rst_led_count", led_change_count, 0);
    check("rst_watchdog", watchdog_expired, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Loopback, back to back
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_drain(400);

    // Even parity: 0x03 has even ones so its parity bit is 0; send 1 instead.
    q_par.push_back({2'b01, 8'h03});
    bb_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    q_par.push_back({2'b00, 8'h07});
    bb_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_drain(200);

    // Stop-bit error, then a short glitch that must not be taken as a frame
    bb_en = 1'b1;
    q_main.push_back({2'b10, 8'h5A});
    bb_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    wait_drain(200);
    drive_bb(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    drive_bb(0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("glitch_no_push", rx_valid, 0);
    bb_en = 1'b0;

    // Overflow: 17 bytes into 16 entries, byte 16 dropped
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_byte(8'(i), (i < 16));
    repeat (20) @(posedge clk);
    #1;
    check("overflow_set", rx_overflow, 1);
    check("full_valid", rx_valid, 1);
    rx_ready = 1'b1;
    wait_drain(100);
    repeat (2) @(posedge clk);
    #1;
    check("drained_valid", rx_valid, 0);

    // LED tracker and watchdog. Reset loads 0x00, so the 0x01 level costs one change.
    @(negedge clk);
    reset = 1'b1;
    led   = 8'h01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("led_count_init", led_change_count, 1);
    pulses = 0;
    step_led(8'h02, 6, pulses);
    step_led(8'h02, 6, pulses);
    step_led(8'h80, 6, pulses);
    check("led_pulses", pulses, 2);
    check("led_count", led_change_count, 3);
    check("led_value", led_value, 8'h80);
    // 0x80 is set after edge P0: led_value at P1, pulse at P2, counter cleared at P3,
    // reaching 1000 at P1003.
    n = 6;
    while (!watchdog_expired && n < 1200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("watchdog_cycles", n, 1003);

    // Reset in the middle of data bit 1 of 0x55 (a 0 bit)
    @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("mid_bit_line", dut_uart_rx, 0);
    #2;
    reset = 1'b1;
    #1;
    check("abort_uart_rx", dut_uart_rx, 1);
    check("abort_tx_ready", tx_ready, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    send_byte(8'hC3, 1'b1);
    wait_drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
